i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
Downstream output stage of audio_equalizer. Accepts signed PCM samples from audio_out through a valid/ready handshake and buffers them in a small FIFO. Serializes each sample as a standard Philips I2S stereo frame to the external DAC, sending the same mono sample on the left and right channels. Generates BCLK and LRCLK internally from clk.

Parameters:
SAMPLE_W, 16, sample width in bits; the frame is 2*SAMPLE_W BCLK periods.
BCLK_DIV, 4, clk cycles per BCLK period; must be even and >= 2.
FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
sample_in  in  SAMPLE_W  signed two's-complement sample (audio_out of equalizer).
sample_valid  in  1  sample_in holds a valid sample.
sample_ready  out  1  FIFO can accept a sample this cycle.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of samples currently stored.
i2s_bclk  out  1  bit clock.
i2s_lrclk  out  1  word select: 0 = left, 1 = right.
i2s_sdata  out  1  serial data, MSB first.
underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.

Behaviour:
- Reset (reset = 0, async) clears all state: FIFO empty, fifo_level = 0, i2s_bclk = 0, i2s_lrclk = 1, i2s_sdata = 0, underrun = 0, div_cnt = 0, slot counter = 2*SAMPLE_W-1. The held previous word is 0. Asserting reset mid-frame aborts the frame immediately and discards FIFO contents.
- sample_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
- Push occurs when sample_valid && sample_ready; the sample is stored on that clk edge.
- FIFO order is first in, first out. No bypass: a sample pushed in the same cycle as a pop attempt on an empty FIFO is stored and is not transmitted in that frame.
- Clock divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk is registered: low while div_cnt < BCLK_DIV/2, high otherwise.
  - The clk edge on which i2s_bclk goes 1 -> 0 is a "fall tick".
  - The first fall tick is the BCLK_DIV-th rising clk edge after reset deasserts.
- Slot counter (0..2*SAMPLE_W-1) advances by one on each fall tick and wraps. i2s_lrclk and i2s_sdata are registered and change only on fall ticks, so a receiver samples them on the BCLK rising edge.
- i2s_lrclk = 0 in slots 0..SAMPLE_W-1 and 1 in slots SAMPLE_W..2*SAMPLE_W-1.
- Data mapping for word W:
  - Left channel: W[SAMPLE_W-1-(k-1)] in slots k = 1..SAMPLE_W.
  - Right channel: W[SAMPLE_W-1-(k-SAMPLE_W-1)] in slots k = SAMPLE_W+1..2*SAMPLE_W-1.
  - The right LSB W[0] goes out in slot 0 of the next frame (one-BCLK I2S delay).
- Pop: on the fall tick entering slot 0, the FIFO head is popped into the transmit word, and the previous word is kept for its right LSB in slot 0.
  - If the FIFO is empty at that tick, the transmit word is 0 and underrun = 1 for exactly that clk cycle.
  - The first frame after reset underruns unless a sample is pushed before the first fall tick.
- A push and a pop in the same cycle leave fifo_level unchanged. When the FIFO is full, sample_ready is 0; after a pop it rises on the next cycle.
- Data is passed through with no arithmetic; sign is carried by the MSB.

Test Plan:
1. Reset: hold reset low for 3 cycles. Expect sample_ready = 1, fifo_level = 0, bclk = 0, lrclk = 1, sdata = 0. Release reset; the first bclk fall occurs 4 clk cycles later and underrun pulses once, since no push was made.
2. Single word (BCLK_DIV = 4): push 16'h8001 before the first fall tick. Across 128 clk cycles, expect lrclk = 0 for 16 BCLKs then 1 for 16. sdata bits on bclk rises: slot 0 = 0, slots 1..16 = 1,0x14,1; slots 17..31 = 1,0x14; next slot 0 = 1.
3. Signed values: push 16'sd100 then -16'sd100 in consecutive frames. Captured words are 0x0064 (L = R) then 0xFF9C (L = R); no underrun.
4. FIFO full: hold sample_valid = 1 for 6 cycles. Expect 4 accepted, sample_ready = 0 and fifo_level = 4 until the next slot-0 pop. Then fifo_level = 3 and sample_ready = 1 on the following cycle.
5. Starvation: after draining the FIFO, push nothing for 3 frames. Expect underrun to pulse once per frame (every 128 clk cycles), with sdata = 0 for all data slots except the prior word's right LSB in the first slot 0.
6. Reset mid-frame: assert reset during slot 20 with 2 samples queued. Outputs return to reset values asynchronously and fifo_level = 0. After release, the frame restarts and the queued samples are never transmitted.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: buffers mono PCM samples and serialises each one as a
// Philips I2S stereo frame (same word on L and R) with internal BCLK/LRCLK.
module i2s_audio_tx #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata,
  output logic                        underrun
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned FRAME = 2 * SAMPLE_W;
  localparam int unsigned SLW   = $clog2(FRAME);
  localparam int unsigned DW    = $clog2(BCLK_DIV);
  localparam int unsigned IW    = $clog2(SAMPLE_W);

  localparam logic [DW-1:0]  DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0]  DIV_HALF  = DW'(BCLK_DIV / 2);
  localparam logic [SLW-1:0] SLOT_LAST = SLW'(FRAME - 1);
  localparam logic [SLW-1:0] SLOT_RGT  = SLW'(SAMPLE_W);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(FIFO_DEPTH);

  logic [DW-1:0]       div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [SLW-1:0]      slot_q, slot_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                under_q, under_d;
  logic [SAMPLE_W-1:0] tx_q, tx_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];

  logic                fall;
  logic                frame_start;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic [IW-1:0]       idx;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == LVL_FULL);
  assign push         = sample_valid && !full;
  assign fall         = (div_q == DIV_LAST);
  assign frame_start  = fall && (slot_q == SLOT_LAST);
  assign pop          = frame_start && !empty;

  always_comb begin
    div_d  = fall ? '0 : div_q + DW'(1);
    bclk_d = (div_d >= DIV_HALF);
    slot_d = slot_q;
    if (fall) begin
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLW'(1);
    end
  end

  // A frame with nothing queued transmits silence.
  always_comb begin
    tx_d    = tx_q;
    under_d = 1'b0;
    if (frame_start) begin
      tx_d    = pop ? mem_q[rd_q] : '0;
      under_d = empty;
    end
  end

  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Slot 0 still carries the old word's LSB, hence tx_q rather than tx_d.
  always_comb begin
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    idx     = '0;
    if (slot_d > SLOT_RGT) begin
      idx = IW'(FRAME - 32'(slot_d));
    end else if (slot_d != '0) begin
      idx = IW'(SAMPLE_W - 32'(slot_d));
    end
    if (fall) begin
      lrclk_d = (slot_d >= SLOT_RGT);
      sdata_d = (slot_d == '0) ? tx_q[0] : tx_q[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= SLOT_LAST;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      under_q <= 1'b0;
      tx_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      under_q <= under_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= sample_in;
    end
  end

  assign sample_ready = !full;
  assign fifo_level   = cnt_q;
  assign i2s_bclk     = bclk_q;
  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign underrun     = under_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: decodes frames on BCLK rises
// and compares them with hand-computed words and timings.
module tb_i2s_audio_tx;

  localparam logic [15:0] VALS [6] = '{
    16'h1234, 16'hA5C3, 16'h7FFF, 16'h0F0F, 16'hDEAD, 16'hBEEF
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [2:0]  fifo_level;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ur_cnt = 0;
  int ur_last = 0;
  int ur_gap = 0;
  logic [31:0] last_sd;

  i2s_audio_tx #(
    .SAMPLE_W(16),
    .BCLK_DIV(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .fifo_level(fifo_level),
    .i2s_bclk(i2s_bclk),
    .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (underrun) begin
      ur_cnt++;
      ur_gap  = cyc - ur_last;
      ur_last = cyc;
    end
  end

  task automatic next_rise(output logic sd, output logic lr);
    logic prev;
    bit   got;
    prev = i2s_bclk;
    got  = 0;
    sd   = 1'b0;
    lr   = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (!prev && i2s_bclk) begin
        got = 1;
        sd  = i2s_sdata;
        lr  = i2s_lrclk;
      end
      prev = i2s_bclk;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bclk_rise_timeout got=none exp=rise within 10 clk");
    end
  endtask

  task automatic capture_frame(output logic [31:0] sd_v,
                               output logic [31:0] lr_v);
    logic s, l;
    sd_v = '0;
    lr_v = '0;
    for (int k = 0; k < 32; k++) begin
      next_rise(s, l);
      sd_v = {sd_v[30:0], s};
      lr_v = {lr_v[30:0], l};
    end
  endtask

  task automatic hold_reset();
    sample_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic prev;
    int   n;
    hold_reset();
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%b exp=1", sample_ready);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level);
    end
    checks++;
    if (i2s_bclk !== 1'b0) begin
      errors++; $display("FAIL rst_bclk got=%b exp=0", i2s_bclk);
    end
    checks++;
    if (i2s_lrclk !== 1'b1) begin
      errors++; $display("FAIL rst_lrclk got=%b exp=1", i2s_lrclk);
    end
    checks++;
    if (i2s_sdata !== 1'b0) begin
      errors++; $display("FAIL rst_sdata got=%b exp=0", i2s_sdata);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL rst_underrun got=%b exp=0", underrun);
    end
    reset = 1'b1;
    prev = i2s_bclk;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (prev && !i2s_bclk) n = i;
      prev = i2s_bclk;
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL first_fall got=%0d exp=4", n);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL first_underrun got=%b exp=1", underrun);
    end
    checks++;
    if (i2s_lrclk !== 1'b0) begin
      errors++; $display("FAIL slot0_lrclk got=%b exp=0", i2s_lrclk);
    end
    @(negedge clk);
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_width got=%b exp=0", underrun);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] sd, lr;
    logic s, l;
    int u0;
    hold_reset();
    sample_in = 16'h8001;
    sample_valid = 1'b1;
    u0 = ur_cnt;
    reset = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    next_rise(s, l);
    checks++;
    if (l !== 1'b1) begin
      errors++; $display("FAIL pre_frame_lr got=%b exp=1", l);
    end
    capture_frame(sd, lr);
    checks++;
    if (sd !== {1'b0, 16'h8001, 15'h4000}) begin
      errors++;
      $display("FAIL single_bits got=%h exp=%h", sd,
               {1'b0, 16'h8001, 15'h4000});
    end
    checks++;
    if (lr !== 32'h0000FFFF) begin
      errors++; $display("FAIL single_lrclk got=%h exp=0000ffff", lr);
    end
    checks++;
    if (ur_cnt - u0 !== 0) begin
      errors++; $display("FAIL single_underrun got=%0d exp=0", ur_cnt - u0);
    end
    next_rise(s, l);
    checks++;
    if (s !== 1'b1) begin
      errors++; $display("FAIL single_rlsb got=%b exp=1", s);
    end
  endtask

  task automatic test_signed();
    logic [31:0] f1, f2, lr;
    logic s, l;
    int u0, du;
    hold_reset();
    sample_in = 16'sd100;
    sample_valid = 1'b1;
    u0 = ur_cnt;
    reset = 1'b1;
    @(negedge clk);
    sample_in = -16'sd100;
    @(negedge clk);
    sample_valid = 1'b0;
    capture_frame(f1, lr);
    capture_frame(f2, lr);
    du = ur_cnt - u0;
    next_rise(s, l);
    checks++;
    if (f1[30:15] !== 16'h0064) begin
      errors++; $display("FAIL pos_left got=%h exp=0064", f1[30:15]);
    end
    checks++;
    if ({f1[14:0], f2[31]} !== 16'h0064) begin
      errors++;
      $display("FAIL pos_right got=%h exp=0064", {f1[14:0], f2[31]});
    end
    checks++;
    if (f2[30:15] !== 16'hFF9C) begin
      errors++; $display("FAIL neg_left got=%h exp=ff9c", f2[30:15]);
    end
    checks++;
    if ({f2[14:0], s} !== 16'hFF9C) begin
      errors++;
      $display("FAIL neg_right got=%h exp=ff9c", {f2[14:0], s});
    end
    checks++;
    if (du !== 0) begin
      errors++; $display("FAIL signed_underrun got=%0d exp=0", du);
    end
  endtask

  task automatic test_fifo_full();
    int acc, n, early;
    hold_reset();
    reset = 1'b1;
    repeat (8) @(negedge clk);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_in = VALS[i];
      if (sample_ready) acc++;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checks++;
    if (acc !== 4) begin
      errors++; $display("FAIL full_accepted got=%0d exp=4", acc);
    end
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL full_level got=%0d exp=4", fifo_level);
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready got=%b exp=0", sample_ready);
    end
    n = 14;
    early = 0;
    while (fifo_level == 3'd4 && n < 400) begin
      @(negedge clk);
      n++;
      if (fifo_level == 3'd4 && sample_ready) early++;
    end
    checks++;
    if (early !== 0) begin
      errors++; $display("FAIL full_ready_held got=%0d exp=0", early);
    end
    checks++;
    if (n !== 132) begin
      errors++; $display("FAIL pop_cycle got=%0d exp=132", n);
    end
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++; $display("FAIL pop_level got=%0d exp=3", fifo_level);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL pop_ready got=%b exp=1", sample_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] f [4];
    logic [31:0] lr;
    for (int i = 0; i < 4; i++) capture_frame(f[i], lr);
    last_sd = f[3];
    checks++;
    if (f[0][31] !== 1'b0) begin
      errors++; $display("FAIL b2b_slot0 got=%b exp=0", f[0][31]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (f[i][30:15] !== VALS[i]) begin
        errors++;
        $display("FAIL b2b_left%0d got=%h exp=%h", i, f[i][30:15], VALS[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({f[i][14:0], f[i+1][31]} !== VALS[i]) begin
        errors++;
        $display("FAIL b2b_right%0d got=%h exp=%h", i,
                 {f[i][14:0], f[i+1][31]}, VALS[i]);
      end
    end
  endtask

  task automatic test_starvation();
    logic [31:0] g0, g1, g2, lr;
    logic [15:0] w3;
    int u0, du;
    w3 = VALS[3];
    u0 = ur_cnt;
    capture_frame(g0, lr);
    capture_frame(g1, lr);
    capture_frame(g2, lr);
    du = ur_cnt - u0;
    checks++;
    if ({last_sd[14:0], g0[31]} !== w3) begin
      errors++;
      $display("FAIL starve_rlsb got=%h exp=%h", {last_sd[14:0], g0[31]}, w3);
    end
    checks++;
    if (g0[30:0] !== 31'd0) begin
      errors++; $display("FAIL starve_f0 got=%h exp=0", g0[30:0]);
    end
    checks++;
    if (g1 !== 32'd0 || g2 !== 32'd0) begin
      errors++; $display("FAIL starve_f12 got=%h/%h exp=0/0", g1, g2);
    end
    checks++;
    if (du !== 3) begin
      errors++; $display("FAIL starve_underruns got=%0d exp=3", du);
    end
    checks++;
    if (ur_gap !== 128) begin
      errors++; $display("FAIL starve_period got=%0d exp=128", ur_gap);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] sd, lr;
    logic s, l, prev;
    int n;
    hold_reset();
    sample_in = 16'h1111;
    sample_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    sample_in = 16'h2222;
    @(negedge clk);
    sample_in = 16'h3333;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int k = 0; k <= 20; k++) next_rise(s, l);
    checks++;
    if (fifo_level !== 3'd2 || l !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got=lvl%0d/lr%b exp=lvl2/lr1", fifo_level, l);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, underrun} !== 4'b0100) begin
      errors++;
      $display("FAIL mid_outputs got=%b exp=0100",
               {i2s_bclk, i2s_lrclk, i2s_sdata, underrun});
    end
    checks++;
    if (fifo_level !== 3'd0 || sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_fifo got=lvl%0d/rdy%b exp=lvl0/rdy1",
               fifo_level, sample_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    prev = i2s_bclk;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(negedge clk);
      if (prev && !i2s_bclk) n = i;
      prev = i2s_bclk;
    end
    checks++;
    if (n !== 4 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart got=fall%0d/ur%b exp=fall4/ur1", n, underrun);
    end
    capture_frame(sd, lr);
    checks++;
    if (sd !== 32'd0) begin
      errors++; $display("FAIL mid_discard got=%h exp=0", sd);
    end
    checks++;
    if (lr !== 32'h0000FFFF) begin
      errors++; $display("FAIL mid_lrclk got=%h exp=0000ffff", lr);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_signed();
    test_fifo_full();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
